// File: rtl/fetch_pkg.sv
// Shared fetch-stage definitions: FSM state encoding and next-PC select codes.
// The fetch datapath decodes SEL_DIR with the same SEL_* constants.
package fetch_pkg;

   localparam logic [1:0] ST_BOOT = 2'd0;
   localparam logic [1:0] ST_RUN  = 2'd1;
   localparam logic [1:0] ST_WAIT = 2'd2;
   localparam logic [1:0] ST_HALT = 2'd3;

   localparam logic [1:0] SEL_PC4 = 2'b00;
   localparam logic [1:0] SEL_JR  = 2'b01;
   localparam logic [1:0] SEL_JMP = 2'b10;

   // jmp_exe outranks jr_exe when both resolve in the same cycle
   function automatic logic [1:0] redirect_sel(input logic jmp, input logic jr);
      logic [1:0] sel;
      sel = SEL_PC4;
      if (jmp)     sel = SEL_JMP;
      else if (jr) sel = SEL_JR;
      return sel;
   endfunction

endpackage

// File: rtl/fetch_control_if.sv
// Handshake bundle between the pipeline and the fetch sequencer.
// Optional statistics outputs exist only when FETCH_CTRL_STATS_EN is defined.
interface fetch_control_if #(parameter int unsigned CNT_W = 16);

   logic       jmp_exe;
   logic       jr_exe;
   logic       load_use;
   logic       imem_ready;
   logic       halt_req;
   logic [1:0] SEL_DIR;
   logic       pc_en;
   logic       ifid_en;
   logic       ifid_flush;
   logic       idex_flush;
   logic       halted;
   logic       boot_done;

`ifdef FETCH_CTRL_STATS_EN
   logic [CNT_W-1:0] stall_cnt;
   logic [CNT_W-1:0] wait_cnt;
   logic [CNT_W-1:0] redirect_cnt;

   modport master (
      output jmp_exe, jr_exe, load_use, imem_ready, halt_req,
      input  SEL_DIR, pc_en, ifid_en, ifid_flush, idex_flush, halted, boot_done,
      input  stall_cnt, wait_cnt, redirect_cnt
   );

   modport slave (
      input  jmp_exe, jr_exe, load_use, imem_ready, halt_req,
      output SEL_DIR, pc_en, ifid_en, ifid_flush, idex_flush, halted, boot_done,
      output stall_cnt, wait_cnt, redirect_cnt
   );
`else
   // width only matters for the statistics build
   if (CNT_W == 0) begin : g_no_cnt_w
   end

   modport master (
      output jmp_exe, jr_exe, load_use, imem_ready, halt_req,
      input  SEL_DIR, pc_en, ifid_en, ifid_flush, idex_flush, halted, boot_done
   );

   modport slave (
      input  jmp_exe, jr_exe, load_use, imem_ready, halt_req,
      output SEL_DIR, pc_en, ifid_en, ifid_flush, idex_flush, halted, boot_done
   );
`endif

endinterface

// File: rtl/fetch_ctrl_sat_cnt.sv
// Saturating event counter used for fetch statistics; holds at all-ones.
module fetch_ctrl_sat_cnt #(
   parameter int unsigned W = 16
) (
   input  logic         clk_i,
   input  logic         rst_ni,
   input  logic         inc_i,
   output logic [W-1:0] cnt_o
);

   logic [W-1:0] cnt_q, cnt_d;

   // advance on each event until the counter reaches all-ones
   always_comb begin
      cnt_d = cnt_q;
      if (inc_i && (cnt_q != '1))
         cnt_d = cnt_q + {{(W-1){1'b0}}, 1'b1};
   end

   // counter register, cleared by reset
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) cnt_q <= '0;
      else         cnt_q <= cnt_d;
   end

   assign cnt_o = cnt_q;

endmodule

// File: rtl/fetch_control.sv
// Fetch-stage sequencer: boot delay, redirect/halt/stall/wait arbitration.
// Outputs are Mealy (state + current inputs). Optional statistics counters
// are built when FETCH_CTRL_STATS_EN is defined.
module fetch_control
   import fetch_pkg::*;
#(
   parameter int unsigned BOOT_CYCLES = 4,
   parameter int unsigned CNT_W       = 16
) (
   input  logic            reloj,
   input  logic            reset_n,
   fetch_control_if.slave  fif
);

   localparam logic [7:0] BOOT_LAST = 8'(BOOT_CYCLES - 1);

   logic [1:0] state_q, state_d;
   logic [7:0] boot_cnt_q, boot_cnt_d;
   logic       boot_done_q, boot_done_d;
   logic       redirect_req;

   assign redirect_req = fif.jmp_exe | fif.jr_exe;

   // next state and Mealy outputs, priority redirect > halt > load-use > imem wait
   always_comb begin
      state_d        = state_q;
      boot_cnt_d     = boot_cnt_q;
      boot_done_d    = boot_done_q;
      fif.SEL_DIR    = SEL_PC4;
      fif.pc_en      = 1'b0;
      fif.ifid_en    = 1'b0;
      fif.ifid_flush = 1'b0;
      fif.idex_flush = 1'b0;
      fif.halted     = 1'b0;
      case (state_q)
         ST_BOOT: begin
            fif.ifid_flush = 1'b1;
            fif.idex_flush = 1'b1;
            boot_cnt_d     = boot_cnt_q + 8'd1;
            if (boot_cnt_q == BOOT_LAST) begin
               state_d     = ST_RUN;
               boot_done_d = 1'b1;
            end
         end
         ST_HALT: begin
            fif.halted     = 1'b1;
            fif.ifid_flush = 1'b1;
            fif.idex_flush = 1'b1;
            // a redirect arriving while halted still steers the PC
            if (redirect_req) begin
               fif.SEL_DIR = redirect_sel(fif.jmp_exe, fif.jr_exe);
               fif.pc_en   = 1'b1;
            end
            state_d = fif.halt_req ? ST_HALT : ST_RUN;
         end
         default: begin
            // RUN and WAIT share one priority list
            if (redirect_req) begin
               fif.SEL_DIR    = redirect_sel(fif.jmp_exe, fif.jr_exe);
               fif.pc_en      = 1'b1;
               fif.ifid_flush = 1'b1;
               fif.idex_flush = 1'b1;
               state_d        = ST_RUN;
            end else if (fif.halt_req) begin
               fif.ifid_flush = 1'b1;
               state_d        = ST_HALT;
            end else if (fif.load_use) begin
               fif.idex_flush = 1'b1;
               state_d        = ST_RUN;
            end else if (!fif.imem_ready) begin
               state_d        = ST_WAIT;
            end else begin
               fif.pc_en      = 1'b1;
               fif.ifid_en    = 1'b1;
               state_d        = ST_RUN;
            end
         end
      endcase
   end

   // state, boot counter and sticky boot flag
   always_ff @(posedge reloj or negedge reset_n) begin
      if (!reset_n) begin
         state_q     <= ST_BOOT;
         boot_cnt_q  <= '0;
         boot_done_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         boot_cnt_q  <= boot_cnt_d;
         boot_done_q <= boot_done_d;
      end
   end

   assign fif.boot_done = boot_done_q;

`ifdef FETCH_CTRL_STATS_EN
   logic redirect_ev, stall_ev, wait_ev, run_or_wait;

   assign run_or_wait = (state_q == ST_RUN) || (state_q == ST_WAIT);
   assign redirect_ev = (state_q != ST_BOOT) && redirect_req;
   assign stall_ev    = run_or_wait && !redirect_req && !fif.halt_req && fif.load_use;
   assign wait_ev     = (state_q == ST_WAIT);

   fetch_ctrl_sat_cnt #(.W(CNT_W)) u_stall_cnt (
      .clk_i (reloj), .rst_ni (reset_n), .inc_i (stall_ev),    .cnt_o (fif.stall_cnt)
   );
   fetch_ctrl_sat_cnt #(.W(CNT_W)) u_wait_cnt (
      .clk_i (reloj), .rst_ni (reset_n), .inc_i (wait_ev),     .cnt_o (fif.wait_cnt)
   );
   fetch_ctrl_sat_cnt #(.W(CNT_W)) u_redirect_cnt (
      .clk_i (reloj), .rst_ni (reset_n), .inc_i (redirect_ev), .cnt_o (fif.redirect_cnt)
   );
`else
   // width only matters for the statistics build
   if (CNT_W == 0) begin : g_no_cnt_w
   end
`endif

endmodule

// File: tb/tb_fetch_control.sv
// Self-checking bench for fetch_control (BOOT_CYCLES = 4).
// Define FETCH_CTRL_STATS_EN to also exercise the statistics counters (CNT_W = 2).
module tb_fetch_control;

`ifdef FETCH_CTRL_STATS_EN
   localparam int unsigned TB_CNT_W = 2;
`else
   localparam int unsigned TB_CNT_W = 16;
`endif

   logic clk;
   logic rst_n;

   fetch_control_if #(.CNT_W(TB_CNT_W)) fif ();

   fetch_control #(.BOOT_CYCLES(4), .CNT_W(TB_CNT_W)) dut (
      .reloj   (clk),
      .reset_n (rst_n),
      .fif     (fif)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_cmp  = 0;
   int n_fail = 0;

   // output vector: {SEL_DIR[1:0], pc_en, ifid_en, ifid_flush, idex_flush, halted, boot_done}
   // care masks zero the bits the behaviour leaves open in that situation
   localparam logic [7:0] E_B  = 8'b00_0011_00, C_B  = 8'b11_1111_11;
   localparam logic [7:0] E_N  = 8'b00_1100_01, C_N  = 8'b11_1111_11;
   localparam logic [7:0] E_J  = 8'b10_1011_01, C_J  = 8'b11_1011_11;
   localparam logic [7:0] E_R  = 8'b01_1011_01, C_R  = 8'b11_1011_11;
   localparam logic [7:0] E_LU = 8'b00_0001_01, C_LU = 8'b11_1101_11;
   localparam logic [7:0] E_W  = 8'b00_0000_01, C_W  = 8'b11_1110_11;
   localparam logic [7:0] E_HE = 8'b00_0010_01, C_HE = 8'b00_1110_11;
   localparam logic [7:0] E_H  = 8'b00_0001_11, C_H  = 8'b00_1101_11;
   localparam logic [7:0] E_HJ = 8'b10_1000_11, C_HJ = 8'b11_1000_11;
   localparam logic [7:0] E_HR = 8'b01_1000_11, C_HR = 8'b11_1000_11;

   // inputs: {jmp_exe, jr_exe, load_use, imem_ready, halt_req}
   typedef struct {
      logic [4:0] in;
      logic [7:0] exp;
      logic [7:0] care;
      string      name;
   } vec_t;

   typedef struct {
      logic [7:0] exp;
      logic [7:0] care;
      string      name;
   } sb_t;

   vec_t tbl[$];
   sb_t  sbq[$];

   function automatic logic [7:0] obs();
      return {fif.SEL_DIR, fif.pc_en, fif.ifid_en, fif.ifid_flush,
              fif.idex_flush, fif.halted, fif.boot_done};
   endfunction

   task automatic drive(input logic [4:0] in);
      {fif.jmp_exe, fif.jr_exe, fif.load_use, fif.imem_ready, fif.halt_req} = in;
   endtask

   task automatic check_front();
      sb_t        e;
      logic [7:0] act;
      if (sbq.size() == 0) begin
         n_cmp++;
         n_fail++;
         $display("FAIL scoreboard_empty: got no entry, want one");
      end else begin
         e   = sbq.pop_front();
         act = obs();
         n_cmp++;
         if ((act & e.care) !== (e.exp & e.care)) begin
            n_fail++;
            $display("FAIL %s: got %b want %b (care %b)", e.name, act, e.exp, e.care);
         end
      end
   endtask

   task automatic cmp_val(input string name, input int act, input int exp);
      n_cmp++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d want %0d", name, act, exp);
      end
   endtask

   // one cycle: drive after the rising edge, compare at the falling edge
   task automatic step(input logic [4:0] in, input logic [7:0] exp,
                       input logic [7:0] care, input string name);
      sb_t e;
      drive(in);
      e.exp = exp; e.care = care; e.name = name;
      sbq.push_back(e);
      @(negedge clk);
      check_front();
      @(posedge clk);
      #1;
   endtask

   task automatic add(input logic [4:0] in, input logic [7:0] exp,
                      input logic [7:0] care, input string name);
      vec_t v;
      v.in = in; v.exp = exp; v.care = care; v.name = name;
      tbl.push_back(v);
   endtask

   // structural invariants checked every running cycle
   always @(negedge clk) begin
      if (rst_n) begin
         n_cmp++;
         if ((fif.SEL_DIR == 2'b11) || (fif.ifid_en && !fif.pc_en)) begin
            n_fail++;
            $display("FAIL invariant: got sel=%b pc_en=%b ifid_en=%b want sel!=11 and ifid_en->pc_en",
                     fif.SEL_DIR, fif.pc_en, fif.ifid_en);
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL timeout: simulation exceeded time limit");
      $fatal(1);
   end

   initial begin
      add(5'b00010, E_B,  C_B,  "boot1");
      add(5'b10010, E_B,  C_B,  "boot_ign_jmp");
      add(5'b00011, E_B,  C_B,  "boot_ign_halt");
      add(5'b00110, E_B,  C_B,  "boot_ign_lu");
      add(5'b00010, E_N,  C_N,  "boot_exit");
      add(5'b11010, E_J,  C_J,  "redir_both");
      add(5'b00010, E_N,  C_N,  "redir_after");
      add(5'b00110, E_LU, C_LU, "lu1");
      add(5'b00110, E_LU, C_LU, "lu2");
      add(5'b00010, E_N,  C_N,  "lu_resume");
      add(5'b00000, E_W,  C_W,  "wait1");
      add(5'b01000, E_R,  C_R,  "wait_jr");
      add(5'b00000, E_W,  C_W,  "wait3");
      add(5'b00010, E_N,  C_N,  "wait_end");
      add(5'b00010, E_N,  C_N,  "run");
      add(5'b00011, E_HE, C_HE, "halt_enter");
      for (int i = 0; i < 4; i++) add(5'b00011, E_H, C_H, "halt_hold");
      add(5'b00010, E_H,  C_H,  "halt_release");
      add(5'b00010, E_N,  C_N,  "halt_resume");
      add(5'b00011, E_HE, C_HE, "halt_enter2");
      add(5'b10011, E_HJ, C_HJ, "halt_jmp");
      add(5'b00011, E_H,  C_H,  "halt_kept");
      add(5'b01010, E_HR, C_HR, "halt_jr_exit");
      add(5'b00010, E_N,  C_N,  "after_halt_jr");
      add(5'b00000, E_W,  C_W,  "wait_again");
      add(5'b00001, E_HE, C_HE, "wait_halt");
      add(5'b00000, E_H,  C_H,  "halt_rel_wait");
      add(5'b00010, E_N,  C_N,  "resume2");
      add(5'b00100, E_LU, C_LU, "lu_beats_wait");
      add(5'b00000, E_W,  C_W,  "wait_after_lu");
      add(5'b00010, E_N,  C_N,  "wait_end2");

      // reset held for three cycles, then released just after a rising edge
      rst_n = 1'b0;
      drive(5'b00010);
      #1;
      for (int i = 0; i < 3; i++) step(5'b00010, E_B, C_B, "reset");
      rst_n = 1'b1;

      foreach (tbl[i]) step(tbl[i].in, tbl[i].exp, tbl[i].care, tbl[i].name);

      // asynchronous reset in the middle of a running cycle
      drive(5'b00010);
      #2;
      rst_n = 1'b0;
      #1;
      begin
         sb_t e;
         e.exp = E_B; e.care = C_B; e.name = "async_reset";
         sbq.push_back(e);
         check_front();
      end
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      for (int i = 0; i < 4; i++) step(5'b10010, E_B, C_B, "reboot");
      step(5'b00010, E_N, C_N, "reboot_exit");

`ifdef FETCH_CTRL_STATS_EN
      cmp_val("redirect_cnt_boot", int'(fif.redirect_cnt), 0);
      cmp_val("stall_cnt_boot",    int'(fif.stall_cnt),    0);
      cmp_val("wait_cnt_boot",     int'(fif.wait_cnt),     0);
      for (int i = 1; i <= 5; i++) begin
         step(5'b10010, E_J, C_J, "stats_jmp");
         cmp_val("redirect_cnt_sat", int'(fif.redirect_cnt), (i > 3) ? 3 : i);
      end
      step(5'b00110, E_LU, C_LU, "stats_lu");
      cmp_val("stall_cnt", int'(fif.stall_cnt), 1);
      step(5'b00000, E_W, C_W, "stats_wait1");
      cmp_val("wait_cnt_enter", int'(fif.wait_cnt), 0);
      step(5'b00000, E_W, C_W, "stats_wait2");
      step(5'b00010, E_N, C_N, "stats_wait_end");
      cmp_val("wait_cnt", int'(fif.wait_cnt), 2);
      rst_n = 1'b0;
      #1;
      cmp_val("redirect_cnt_rst", int'(fif.redirect_cnt), 0);
      cmp_val("stall_cnt_rst",    int'(fif.stall_cnt),    0);
      cmp_val("wait_cnt_rst",     int'(fif.wait_cnt),     0);
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      step(5'b00010, E_B, C_B, "stats_reboot");
`endif

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
